// File: rtl/steer_x_sequencer.sv
// Rear-wheel steering sequencer: maps JSTK2 X samples to a direction and duty, slews the duty and enforces dead time on reversal.
// Latency: a sample is captured one cycle after x_valid and acts at the next period_start; outputs update the cycle after period_start.
// Backpressure: none; x_valid and period_start are single-cycle strobes and are consumed the cycle they are seen.
//
// Ports:
//   clk, rst          system clock, asynchronous active-high reset
//   x_val, x_valid    10-bit X sample and its one-cycle strobe
//   period_start      strobe when the shared PWM period counter wraps to 0
//   duty              compare value for the active comparator (registered)
//   pwm_en_left/right comparator enables (registered, never both high)
//   state             0 IDLE, 1 DRIVE, 2 DEAD
//   timeout           high while the failsafe stop is active
module steer_x_sequencer #(
   parameter int unsigned CENTER          = 512,
   parameter int unsigned DEADBAND        = 40,
   parameter int unsigned DUTY_MAX        = 3800,
   parameter int unsigned STEP            = 64,
   parameter int unsigned RAMP_DIV        = 4,
   parameter int unsigned DEAD_PERIODS    = 8,
   parameter int unsigned TIMEOUT_PERIODS = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [9:0]  x_val,
   input  logic        x_valid,
   input  logic        period_start,
   output logic [11:0] duty,
   output logic        pwm_en_left,
   output logic        pwm_en_right,
   output logic [1:0]  state,
   output logic        timeout
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_DRIVE = 2'd1;
   localparam logic [1:0] ST_DEAD  = 2'd2;

   localparam logic [1:0] DIR_NONE  = 2'd0;
   localparam logic [1:0] DIR_RIGHT = 2'd1;
   localparam logic [1:0] DIR_LEFT  = 2'd2;

   localparam int FS_W = $clog2(TIMEOUT_PERIODS + 1);
   localparam int RD_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
   localparam int DD_W = (DEAD_PERIODS > 1) ? $clog2(DEAD_PERIODS) : 1;

   localparam logic [12:0]     HI_TH    = 13'(CENTER + DEADBAND);
   localparam logic [12:0]     LO_TH    = 13'(CENTER - DEADBAND);
   localparam logic [12:0]     DMAX_13  = 13'(DUTY_MAX);
   localparam logic [11:0]     STEP_12  = 12'(STEP);
   localparam logic [FS_W-1:0] FS_SAT   = FS_W'(TIMEOUT_PERIODS);
   localparam logic [RD_W-1:0] RD_LAST  = RD_W'(RAMP_DIV - 1);
   localparam logic [DD_W-1:0] DD_LAST  = DD_W'(DEAD_PERIODS - 1);

   logic [9:0]      x_reg;
   logic [FS_W-1:0] fs_cnt;
   logic [RD_W-1:0] ramp_cnt;
   logic [DD_W-1:0] dead_cnt, dead_nxt;
   logic [11:0]     cur_duty, cur_nxt;
   logic [1:0]      dir, dir_nxt, last_dir, last_nxt, state_nxt;

   logic [12:0] x_ext, mag;
   logic [1:0]  req_dir;
   logic [11:0] req_target, eff_target, ramped, gap;
   logic        tick;

   assign timeout = (fs_cnt == FS_SAT);
   assign tick    = period_start && (ramp_cnt == RD_LAST);
   assign x_ext   = {3'b000, x_reg};

   // Request from the captured sample; the failsafe overrides it to a stop.
   always_comb begin
      req_dir = DIR_NONE;
      mag     = '0;
      if (x_ext > HI_TH) begin
         req_dir = DIR_RIGHT;
         mag     = (x_ext - HI_TH) << 3;
      end else if (x_ext < LO_TH) begin
         req_dir = DIR_LEFT;
         mag     = (LO_TH - x_ext) << 3;
      end
      if (mag > DMAX_13) begin
         mag = DMAX_13;
      end
      req_target = mag[11:0];
      if (timeout) begin
         req_dir    = DIR_NONE;
         req_target = '0;
      end
   end

   // Slew one step toward the effective target, clipped so it never overshoots.
   always_comb begin
      eff_target = (req_dir == dir) ? req_target : 12'd0;
      if (cur_duty < eff_target) begin
         gap    = eff_target - cur_duty;
         ramped = cur_duty + ((gap > STEP_12) ? STEP_12 : gap);
      end else begin
         gap    = cur_duty - eff_target;
         ramped = cur_duty - ((gap > STEP_12) ? STEP_12 : gap);
      end
   end

   always_comb begin
      state_nxt = state;
      dir_nxt   = dir;
      last_nxt  = last_dir;
      cur_nxt   = cur_duty;
      dead_nxt  = dead_cnt;
      if (period_start) begin
         case (state)
            ST_IDLE: begin
               cur_nxt = '0;
               if (req_dir != DIR_NONE) begin
                  if (req_dir == last_dir || last_dir == DIR_NONE) begin
                     state_nxt = ST_DRIVE;
                     dir_nxt   = req_dir;
                  end else begin
                     state_nxt = ST_DEAD;
                     dead_nxt  = '0;
                  end
               end
            end
            ST_DRIVE: begin
               // Direction may only be released once the duty has slewed to zero.
               if (cur_duty == 12'd0 && req_dir == DIR_NONE) begin
                  state_nxt = ST_IDLE;
                  last_nxt  = dir;
                  dir_nxt   = DIR_NONE;
               end else if (cur_duty == 12'd0 && req_dir != dir) begin
                  state_nxt = ST_DEAD;
                  last_nxt  = dir;
                  dir_nxt   = DIR_NONE;
                  dead_nxt  = '0;
               end else if (tick) begin
                  cur_nxt = ramped;
               end
            end
            ST_DEAD: begin
               cur_nxt = '0;
               if (dead_cnt == DD_LAST) begin
                  if (req_dir != DIR_NONE) begin
                     state_nxt = ST_DRIVE;
                     dir_nxt   = req_dir;
                  end else begin
                     state_nxt = ST_IDLE;
                     last_nxt  = DIR_NONE;
                  end
               end else begin
                  dead_nxt = dead_cnt + DD_W'(1);
               end
            end
            default: begin
               state_nxt = ST_IDLE;
               dir_nxt   = DIR_NONE;
               cur_nxt   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x_reg    <= 10'(CENTER);
         fs_cnt   <= '0;
         ramp_cnt <= '0;
      end else begin
         if (x_valid) begin
            x_reg <= x_val;
         end
         // A fresh sample wins over a simultaneous period count.
         if (x_valid) begin
            fs_cnt <= '0;
         end else if (period_start && fs_cnt != FS_SAT) begin
            fs_cnt <= fs_cnt + FS_W'(1);
         end
         if (period_start) begin
            ramp_cnt <= tick ? '0 : ramp_cnt + RD_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         dir      <= DIR_NONE;
         last_dir <= DIR_NONE;
         cur_duty <= '0;
         dead_cnt <= '0;
      end else begin
         state    <= state_nxt;
         dir      <= dir_nxt;
         last_dir <= last_nxt;
         cur_duty <= cur_nxt;
         dead_cnt <= dead_nxt;
      end
   end

   // Outputs load from the next-state values only at a period boundary so the
   // comparators never see a mid-period change; a single dir_nxt makes both
   // enables high at once impossible.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         duty         <= '0;
         pwm_en_left  <= 1'b0;
         pwm_en_right <= 1'b0;
      end else if (period_start) begin
         duty         <= cur_nxt;
         pwm_en_left  <= (state_nxt == ST_DRIVE) && (dir_nxt == DIR_LEFT);
         pwm_en_right <= (state_nxt == ST_DRIVE) && (dir_nxt == DIR_RIGHT);
      end
   end

endmodule

// File: tb/tb_steer_x_sequencer.sv
// Bench for steer_x_sequencer: steady-state mapping table plus ramp, reversal, failsafe and reset sequences.
// Latency: one PWM period is modelled as 4 clocks with period_start on the first.
// Backpressure: none; the bench drives strobes directly.
module tb_steer_x_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [9:0]  x_val = 10'd512;
   logic        x_valid = 1'b0;
   logic        period_start = 1'b0;
   logic [11:0] duty;
   logic        pwm_en_left, pwm_en_right, timeout;
   logic [1:0]  state;

   int checks = 0;
   int errors = 0;
   int both_hi = 0;
   bit feed = 1'b0;

   steer_x_sequencer dut (
      .clk          (clk),
      .rst          (rst),
      .x_val        (x_val),
      .x_valid      (x_valid),
      .period_start (period_start),
      .duty         (duty),
      .pwm_en_left  (pwm_en_left),
      .pwm_en_right (pwm_en_right),
      .state        (state),
      .timeout      (timeout)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (pwm_en_left && pwm_en_right) both_hi++;
   end

   typedef struct {
      logic [9:0] x;
      int         duty;
      int         en_l;
      int         en_r;
      int         st;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // One PWM period: strobe, then a mid-period sample when feeding.
   task automatic period();
      @(negedge clk); period_start = 1'b1;
      @(negedge clk); period_start = 1'b0;
      if (feed) x_valid = 1'b1;
      @(negedge clk); x_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) period();
   endtask

   task automatic do_reset();
      @(negedge clk); rst = 1'b1; x_valid = 1'b0; period_start = 1'b0;
      @(negedge clk); rst = 1'b0;
   endtask

   initial begin
      int n, dead, bad_en, bad_mono, bad_dead, prev;

      vecs[0] = '{10'd1023, 3768, 0, 1, 1};
      vecs[1] = '{10'd0,    3776, 1, 0, 1};
      vecs[2] = '{10'd512,  0,    0, 0, 0};
      vecs[3] = '{10'd540,  0,    0, 0, 0};
      vecs[4] = '{10'd552,  0,    0, 0, 0};
      vecs[5] = '{10'd553,  8,    0, 1, 1};
      vecs[6] = '{10'd472,  0,    0, 0, 0};
      vecs[7] = '{10'd471,  8,    1, 0, 1};
      vecs[8] = '{10'd680,  1024, 0, 1, 1};
      vecs[9] = '{10'd300,  1376, 1, 0, 1};

      repeat (3) @(negedge clk);
      chk("reset_duty", int'(duty), 0);
      chk("reset_state", int'(state), 0);
      chk("reset_en", int'(pwm_en_left) + int'(pwm_en_right), 0);
      chk("reset_timeout", int'(timeout), 0);
      rst = 1'b0;

      // Steady-state mapping from reset, samples fed every period.
      feed = 1'b1;
      for (int v = 0; v < 10; v++) begin
         do_reset();
         x_val = vecs[v].x;
         run(250);
         chk($sformatf("vec%0d_duty", v), int'(duty), vecs[v].duty);
         chk($sformatf("vec%0d_en_l", v), int'(pwm_en_left), vecs[v].en_l);
         chk($sformatf("vec%0d_en_r", v), int'(pwm_en_right), vecs[v].en_r);
         chk($sformatf("vec%0d_state", v), int'(state), vecs[v].st);
         chk($sformatf("vec%0d_timeout", v), int'(timeout), 0);
      end

      // Asynchronous reset while driving left, with a sample strobed during reset.
      @(negedge clk); #2 rst = 1'b1;
      #1;
      chk("async_rst_duty", int'(duty), 0);
      chk("async_rst_en_l", int'(pwm_en_left), 0);
      chk("async_rst_state", int'(state), 0);
      x_val = 10'd1023;
      @(negedge clk); x_valid = 1'b1;
      @(negedge clk); x_valid = 1'b0;
      chk("rst_hold_en_r", int'(pwm_en_right), 0);
      rst = 1'b0;

      // Ramp-up cadence: drive starts at period 2, one step every 4th period.
      for (int p = 1; p <= 250; p++) begin
         period();
         if (p == 2) begin
            chk("ramp_p2_en_r", int'(pwm_en_right), 1);
            chk("ramp_p2_duty", int'(duty), 0);
         end
         if (p == 3) chk("ramp_p3_duty", int'(duty), 0);
         if (p == 4) chk("ramp_p4_duty", int'(duty), 64);
         if (p == 7) chk("ramp_p7_duty", int'(duty), 64);
         if (p == 8) chk("ramp_p8_duty", int'(duty), 128);
         if (p == 12) chk("ramp_p12_duty", int'(duty), 192);
      end
      chk("ramp_settle_duty", int'(duty), 3768);
      chk("ramp_settle_en_l", int'(pwm_en_left), 0);

      // Reversal: slew to zero still driving right, then 8 dead periods.
      x_val = 10'd0;
      n = 0; bad_en = 0; bad_mono = 0; prev = int'(duty);
      while (state != 2'd2 && n < 400) begin
         period();
         n++;
         if (state == 2'd1) begin
            if (pwm_en_right !== 1'b1 || pwm_en_left !== 1'b0) bad_en++;
            if (int'(duty) > prev) bad_mono++;
         end
         prev = int'(duty);
      end
      chk("rev_reached_dead", int'(state), 2);
      chk("rev_rampdown_en", bad_en, 0);
      chk("rev_rampdown_mono", bad_mono, 0);
      chk("rev_dead_duty", int'(duty), 0);
      dead = 0; bad_dead = 0;
      while (state == 2'd2 && dead < 20) begin
         if (pwm_en_left || pwm_en_right) bad_dead++;
         dead++;
         period();
      end
      chk("rev_dead_periods", dead, 8);
      chk("rev_dead_en", bad_dead, 0);
      chk("rev_left_en_l", int'(pwm_en_left), 1);
      chk("rev_left_state", int'(state), 1);
      run(240);
      chk("rev_left_duty", int'(duty), 3776);

      // Mid-period sample must not move outputs before the next boundary.
      do_reset();
      x_val = 10'd512;
      run(10);
      @(negedge clk); x_val = 10'd1023; x_valid = 1'b1;
      @(negedge clk); x_valid = 1'b0;
      chk("mid_en_r_a", int'(pwm_en_right), 0);
      chk("mid_state_a", int'(state), 0);
      @(negedge clk);
      chk("mid_en_r_b", int'(pwm_en_right), 0);
      period();
      chk("mid_after_ps_en_r", int'(pwm_en_right), 1);

      // Failsafe: samples stop while driving at 1024.
      do_reset();
      x_val = 10'd680;
      run(80);
      chk("fs_drive_duty", int'(duty), 1024);
      feed = 1'b0;
      n = 0;
      while (!timeout && n < 1100) begin
         period();
         n++;
      end
      chk("fs_periods", n, 1024);
      run(80);
      chk("fs_stop_duty", int'(duty), 0);
      chk("fs_stop_state", int'(state), 0);
      chk("fs_stop_en_r", int'(pwm_en_right), 0);
      chk("fs_stop_timeout", int'(timeout), 1);
      @(negedge clk); x_valid = 1'b1;
      @(negedge clk); x_valid = 1'b0;
      chk("fs_clear", int'(timeout), 0);
      feed = 1'b1;
      run(80);
      chk("fs_resume_state", int'(state), 1);
      chk("fs_resume_en_r", int'(pwm_en_right), 1);
      chk("fs_resume_duty", int'(duty), 1024);

      // Reset during DEAD forgets the last direction.
      do_reset();
      x_val = 10'd680;
      run(80);
      x_val = 10'd300;
      n = 0;
      while (state != 2'd2 && n < 100) begin
         period();
         n++;
      end
      chk("rd_reached_dead", int'(state), 2);
      @(negedge clk); #2 rst = 1'b1;
      #1;
      chk("rd_rst_state", int'(state), 0);
      chk("rd_rst_en", int'(pwm_en_left) + int'(pwm_en_right), 0);
      @(negedge clk); rst = 1'b0;
      x_val = 10'd0;
      run(2);
      chk("rd_left_state", int'(state), 1);
      chk("rd_left_en_l", int'(pwm_en_left), 1);

      chk("never_both_enables", both_hi, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/steer_x_sequencer.md
Name: steer_x_sequencer

Overview:
- Controller that sequences the rear-wheel PWM datapath (shared 12-bit period counter plus left/right comparators) from JSTK2 X-axis samples.
- Maps each 10-bit sample to a direction and a duty target, applying a deadband around center.
- Slews duty gradually and enforces a zero-duty dead interval on every direction reversal.
- Forces the wheels to a stop when joystick samples stop arriving.
- Sits between the SPI joystick receiver and the left/right PWM comparators.

Parameters:
CENTER, 512, X value treated as stick neutral
DEADBAND, 40, half-width of neutral zone around CENTER
DUTY_MAX, 3800, clamp for any duty value (12-bit)
STEP, 64, max duty change per ramp tick
RAMP_DIV, 4, PWM periods per ramp tick (>=1)
DEAD_PERIODS, 8, PWM periods with both enables low on reversal
TIMEOUT_PERIODS, 1024, PWM periods without x_valid before failsafe stop

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
x_val  in  10  JSTK2 X sample, 0..1023
x_valid  in  1  one-cycle strobe, x_val valid
period_start  in  1  one-cycle strobe when the shared PWM counter wraps to 0
duty  out  12  compare value for the active comparator
pwm_en_left  out  1  enables left (reverse-turn) PWM output
pwm_en_right  out  1  enables right PWM output
state  out  2  0 IDLE, 1 DRIVE, 2 DEAD
timeout  out  1  high while failsafe is active

Behaviour:
- Reset (async, immediate): duty=0, both enables 0, state=IDLE, timeout=0, x_reg=CENTER, cur_duty=0, last_dir=NONE, all counters 0.
- Sample capture: x_reg<=x_val on x_valid. The failsafe counter clears on x_valid.
- Request derived from x_reg, combinationally:
  - x_reg>CENTER+DEADBAND: req_dir=RIGHT, target=min((x_reg-CENTER-DEADBAND)<<3, DUTY_MAX).
  - x_reg<CENTER-DEADBAND: req_dir=LEFT, target=min((CENTER-DEADBAND-x_reg)<<3, DUTY_MAX).
  - Otherwise: req_dir=NONE, target=0.
  - Intermediates are 13-bit. No negative values reach the shift.
- Failsafe:
  - Counter increments on period_start and saturates at TIMEOUT_PERIODS.
  - At saturation, timeout=1 and the request is overridden to NONE/0.
  - The next x_valid clears timeout the following cycle.
- Ramp tick: one tick on every RAMP_DIV-th period_start.
  - On a tick, cur_duty moves toward the effective target by min(STEP, |target-cur_duty|). It never overshoots.
  - Effective target is 0 when req_dir is NONE or differs from the active dir.
- FSM (transitions evaluated on period_start only):
  - IDLE:
    - req_dir==NONE: stay.
    - req_dir==last_dir, or last_dir==NONE: go DRIVE with dir=req_dir.
    - Otherwise: go DEAD.
  - DRIVE:
    - Ramp toward the effective target.
    - When cur_duty==0 and req_dir==NONE: go IDLE (last_dir=dir).
    - When cur_duty==0 and req_dir is opposite: go DEAD (last_dir=dir).
  - DEAD:
    - cur_duty held 0, both enables 0, counts DEAD_PERIODS periods.
    - At the end: go DRIVE with dir=req_dir if req_dir!=NONE. Otherwise go IDLE with last_dir=NONE.
- Output update, glitch-free:
  - duty, pwm_en_left and pwm_en_right are registered and change only on the cycle after period_start.
  - duty<=cur_duty. pwm_en_right = (state==DRIVE && dir==RIGHT). pwm_en_left likewise for LEFT.
  - Both enables high at once is illegal and must never occur.
- Simultaneous x_valid and period_start: the new sample affects the request at the next period_start, not the current one.
- Reset mid-DRIVE: outputs drop to 0 asynchronously. Operation restarts from IDLE.
- x_val at extremes (0, 1023) must clamp at DUTY_MAX without wrap.

Test Plan:
- Reset with x_val=1023 held, x_valid pulsed: all outputs 0 asynchronously while rst=1. After release: duty ramps 0→64→128… every 4 periods, pwm_en_right=1, pwm_en_left=0, settles at 3768.
- x_reg=540 (inside deadband): state stays IDLE, duty=0, both enables 0 indefinitely (given periodic x_valid).
- DRIVE right at 3768, then x_val=0: duty ramps to 0 with pwm_en_right=1. Then state=DEAD for exactly 8 periods with both enables 0. Then pwm_en_left=1, duty ramps toward 3776.
- Stop x_valid while driving at 1024: after 1024 periods timeout=1, duty ramps to 0, state=IDLE. One x_valid clears timeout and driving resumes.
- Pulse x_valid at mid-period: duty and enable outputs change only one cycle after a period_start, never in between.
- Assert rst during DEAD: state=IDLE, enables 0 immediately. After release with x_val=0, left driving starts without a dead interval (last_dir=NONE).
